// File: rtl/mux_scan.sv
// N-channel registered mux with manual select and timed auto-scan.
// Optional channel masking in scan mode is enabled by defining MUX_SCAN_MASK_EN.
module mux_scan #(
   parameter int W     = 1,
   parameter int N     = 8,
   parameter int SW    = 3,
   parameter int DWELL = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic           mode,
   input  logic [SW-1:0]  sel,
   input  logic [N*W-1:0] din,
   input  logic [N-1:0]   ch_mask,
   output logic [W-1:0]   out,
   output logic           out_valid,
   output logic [SW-1:0]  cur_ch,
   output logic           wrap
);

   localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

   typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

   state_t          r_state;
   state_t          w_stateNext;
   logic [W-1:0]    r_out;
   logic            r_valid;
   logic [SW-1:0]   r_curCh;
   logic            r_wrap;
   logic [DW-1:0]   r_dwell;

   logic [SW-1:0]   w_nextCh;
   logic            w_nextWrap;
   logic            w_anyCh;
   logic            w_curOk;
   logic            w_found;
   logic            w_advance;

   assign w_stateNext = !en ? IDLE : (mode ? SCAN : MANUAL);

   // Next channel in scan order; w_curOk drops when the current channel is masked out.
   always_comb begin
      w_nextCh   = r_curCh;
      w_nextWrap = 1'b0;
      w_anyCh    = 1'b1;
      w_curOk    = 1'b1;
      w_found    = 1'b0;
`ifdef MUX_SCAN_MASK_EN
      w_anyCh = |ch_mask;
      w_curOk = ch_mask[r_curCh];
      for (int k = 1; k <= N; k++) begin
         if (!w_found && ch_mask[(int'(r_curCh) + k) % N]) begin
            w_found    = 1'b1;
            w_nextCh   = SW'((int'(r_curCh) + k) % N);
            w_nextWrap = (int'(r_curCh) + k >= N);
         end
      end
`else
      if (int'(r_curCh) == N - 1) begin
         w_nextCh   = '0;
         w_nextWrap = 1'b1;
      end else begin
         w_nextCh = r_curCh + SW'(1);
      end
`endif
   end

`ifndef MUX_SCAN_MASK_EN
   logic w_unusedMask;
   assign w_unusedMask = ^ch_mask;
`endif

   // The entry cycle into SCAN only advances if the starting channel is masked.
   assign w_advance = !w_curOk || (r_state == SCAN && r_dwell == DWELL_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_out   <= '0;
         r_valid <= 1'b0;
         r_curCh <= '0;
         r_wrap  <= 1'b0;
         r_dwell <= '0;
      end else begin
         r_state <= w_stateNext;
         r_wrap  <= 1'b0;
         case (w_stateNext)
            MANUAL: begin
               r_dwell <= '0;
               if (int'(sel) < N) begin
                  r_out   <= din[int'(sel)*W +: W];
                  r_curCh <= sel;
                  r_valid <= 1'b1;
               end else begin
                  r_valid <= 1'b0;
               end
            end
            SCAN: begin
               if (!w_anyCh) begin
                  r_valid <= 1'b0;
                  r_dwell <= '0;
               end else if (w_advance) begin
                  r_curCh <= w_nextCh;
                  r_out   <= din[int'(w_nextCh)*W +: W];
                  r_dwell <= '0;
                  r_wrap  <= w_nextWrap;
                  r_valid <= 1'b1;
               end else begin
                  r_out   <= din[int'(r_curCh)*W +: W];
                  r_valid <= 1'b1;
                  r_dwell <= (r_state == SCAN) ? r_dwell + 1'b1 : '0;
               end
            end
            default: begin
               r_valid <= 1'b0;
               r_dwell <= '0;
            end
         endcase
      end
   end

   assign out       = r_out;
   assign out_valid = r_valid;
   assign cur_ch    = r_curCh;
   assign wrap      = r_wrap;

endmodule

// File: doc/mux_scan.md
MUX_SCAN -- requirements
Module: mux_scan

Interface
REQ-001 Parameter W, default 1: data width per channel.
REQ-002 Parameter N, default 8: channel count, 2..64.
REQ-003 Parameter SW, default 3: select width; SHALL equal ceil(log2(N)).
REQ-004 Parameter DWELL, default 4: cycles per channel in scan mode, 1..256.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 en  input  1  block enable.
REQ-008 mode  input  1  0 = manual select; 1 = auto-scan.
REQ-009 sel  input  SW  manual channel select.
REQ-010 din  input  N*W  packed channels; channel i occupies bits [i*W +: W].
REQ-011 ch_mask  input  N  per-channel scan enable; used only under MUX_SCAN_MASK_EN.
REQ-012 out  output  W  registered selected data.
REQ-013 out_valid  output  1  out holds a valid sample this cycle.
REQ-014 cur_ch  output  SW  channel that produced the current out.
REQ-015 wrap  output  1  one-cycle pulse when a scan pass completes.

Function
REQ-016 The FSM SHALL have three states: IDLE, MANUAL and SCAN. en=0 SHALL select IDLE. en=1 with mode=0 SHALL select MANUAL. en=1 with mode=1 SHALL select SCAN. The transition SHALL take effect on the next edge.
REQ-017 In IDLE, out and cur_ch SHALL hold their values and out_valid and wrap SHALL be 0.
REQ-018 In MANUAL with sel<N, out and cur_ch SHALL update to din[sel] and sel on the next edge (latency 1), and out_valid SHALL be 1.
REQ-019 In MANUAL with sel>=N, out and cur_ch SHALL hold and out_valid SHALL be 0.
REQ-020 In SCAN, out SHALL be loaded every cycle with the current din[cur_ch], so it tracks live data, and out_valid SHALL be 1.
REQ-021 The dwell counter SHALL count 0..DWELL-1. At DWELL-1 the counter SHALL return to 0 and cur_ch SHALL advance to the next channel.
REQ-022 Channel advance from N-1 SHALL wrap to 0 and assert wrap for exactly that cycle.
REQ-023 When entering SCAN from IDLE or MANUAL, the dwell counter SHALL clear and scanning SHALL begin at the current cur_ch.
REQ-024 When leaving SCAN, the dwell counter SHALL clear and wrap SHALL be 0 on the next cycle.
REQ-025 With DWELL=1, the channel SHALL advance every cycle.
REQ-026 A sel change in MANUAL SHALL take effect on the next edge, with no settling cycles.

Reset
REQ-027 When rst=1 on an edge, the block SHALL apply out=0, out_valid=0, cur_ch=0, wrap=0, dwell counter=0 and state=IDLE.
REQ-028 Reset SHALL override en, mode and sel in the same cycle, including during a scan mid-dwell.

Configuration
REQ-029 The macro MUX_SCAN_MASK_EN SHALL control channel masking.
- When defined: SCAN SHALL advance to the next channel with ch_mask=1, in ascending order with wrap.
- When defined: wrap SHALL pulse when the advance passes index N-1.
- When defined: if ch_mask is all zero, out and cur_ch SHALL hold and out_valid SHALL be 0.
- When defined: if cur_ch becomes masked mid-dwell, the block SHALL advance on the next edge.
- When undefined: ch_mask SHALL be ignored and every channel SHALL be scanned.

Verification
REQ-030 Manual, defaults: din=8'b11011001 (i0=1, i3=1, i4=1, i6=1, i7=1), en=1, mode=0, sel stepped 0..7 one per cycle -> out equals din[sel] one cycle later each step; out_valid=1 throughout.
REQ-031 Scan, DWELL=4, N=8 -> cur_ch advances every 4 cycles through 0..7; wrap pulses for one cycle on the 7->0 advance (32 cycles per pass).
REQ-032 Invalid select, N=6, SW=3, sel=7 in MANUAL -> out_valid=0 and out holds its prior value.
REQ-033 Reset mid-dwell: rst=1 at dwell count 2 on channel 5 -> next cycle out=0, cur_ch=0, out_valid=0, state=IDLE.
REQ-034 Masking, MUX_SCAN_MASK_EN defined, ch_mask=8'b10010010 -> scan visits channels 1, 4, 7, 1, ...; wrap pulses on the 7->1 advance; ch_mask=0 -> out_valid=0.
